// File: rtl/branch_resolver.sv
// Branch resolver: captures one branch, evaluates its condition in a single cycle,
// and holds a redirect to fetch on a mispredict until fetch accepts it.
module branch_resolver #(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       opCond,
  input  logic [DBITS-1:0] srcA,
  input  logic [DBITS-1:0] srcB,
  input  logic [DBITS-1:0] pcPlus4,
  input  logic [DBITS-1:0] target,
  input  logic             predTaken,
  output logic             resolve_valid,
  output logic             taken,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [DBITS-1:0] redir_pc,
  output logic             flush,
  output logic [15:0]      taken_count
);

  // One-hot encoding keeps each output a direct decode of one flop.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_EVAL  = 3'b010,
    S_REDIR = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_op;
  logic [DBITS-1:0] r_a;
  logic [DBITS-1:0] r_b;
  logic [DBITS-1:0] r_pc4;
  logic [DBITS-1:0] r_tgt;
  logic             r_pred;
  logic [DBITS-1:0] r_redir_pc;
  logic [15:0]      r_taken_count;
  logic             w_accept;
  logic             w_taken;
  logic [DBITS-1:0] w_diff;

  // Signed compare is a plain subtract: overflow deliberately left uncorrected.
  function automatic logic eval_cond(input logic [3:0] op, input logic [DBITS-1:0] diff);
    logic eq;
    logic lt;
    logic base;
    eq = (diff == {DBITS{1'b0}});
    lt = diff[DBITS-1];
    case (op[1:0])
      2'b00:   base = 1'b0;
      2'b01:   base = eq;
      2'b10:   base = lt;
      2'b11:   base = eq | lt;
      default: base = 1'b0;
    endcase
    return base ^ op[3];
  endfunction

  // Condition evaluation from the captured operands.
  always_comb begin
    w_diff  = r_a - (r_op[2] ? {DBITS{1'b0}} : r_b);
    w_taken = eval_cond(r_op, w_diff);
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    req_ready     = 1'b0;
    resolve_valid = 1'b0;
    taken         = 1'b0;
    redir_valid   = 1'b0;
    flush         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_EVAL;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EVAL: begin
        resolve_valid = 1'b1;
        taken         = w_taken;
        if (w_taken != r_pred) begin
          w_state_next = S_REDIR;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_REDIR: begin
        redir_valid = 1'b1;
        if (redir_ready) begin
          flush        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_REDIR;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= 4'b0000;
      r_a    <= {DBITS{1'b0}};
      r_b    <= {DBITS{1'b0}};
      r_pc4  <= {DBITS{1'b0}};
      r_tgt  <= {DBITS{1'b0}};
      r_pred <= 1'b0;
    end else if (w_accept) begin
      r_op   <= opCond;
      r_a    <= srcA;
      r_b    <= srcB;
      r_pc4  <= pcPlus4;
      r_tgt  <= target;
      r_pred <= predTaken;
    end else begin
      r_op   <= r_op;
      r_a    <= r_a;
      r_b    <= r_b;
      r_pc4  <= r_pc4;
      r_tgt  <= r_tgt;
      r_pred <= r_pred;
    end
  end

  // Corrected PC is latched at resolve time so it stays stable through the redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redir_pc <= {DBITS{1'b0}};
    end else if (r_state == S_EVAL) begin
      r_redir_pc <= w_taken ? r_tgt : r_pc4;
    end else begin
      r_redir_pc <= r_redir_pc;
    end
  end

  // Saturating taken-branch counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_taken_count <= 16'h0000;
    end else if ((r_state == S_EVAL) && w_taken && (r_taken_count != 16'hFFFF)) begin
      r_taken_count <= r_taken_count + 16'h0001;
    end else begin
      r_taken_count <= r_taken_count;
    end
  end

  assign redir_pc    = r_redir_pc;
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: table of single-branch vectors plus
// hand-written redirect-hold, saturation and mid-redirect reset sequences.
module tb_branch_resolver;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  opCond;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] pcPlus4;
  logic [31:0] target;
  logic        predTaken;
  logic        resolve_valid;
  logic        taken;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush;
  logic [15:0] taken_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        pred;
    logic        exp_taken;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  branch_resolver #(.DBITS(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .opCond       (opCond),
    .srcA         (srcA),
    .srcB         (srcB),
    .pcPlus4      (pcPlus4),
    .target       (target),
    .predTaken    (predTaken),
    .resolve_valid(resolve_valid),
    .taken        (taken),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .flush        (flush),
    .taken_count  (taken_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one branch from IDLE and follow it back to IDLE, acking any redirect at once.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_req_ready_idle", idx), {31'd0, req_ready}, 32'd1);
    opCond    = v.op;
    srcA      = v.a;
    srcB      = v.b;
    pcPlus4   = v.pc4;
    target    = v.tgt;
    predTaken = v.pred;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    srcA      = ~v.a;
    srcB      = ~v.b;
    opCond    = ~v.op;
    target    = 32'hDEAD_BEEF;
    pcPlus4   = 32'hBAD0_0000;
    chk($sformatf("v%0d_resolve_valid", idx), {31'd0, resolve_valid}, 32'd1);
    chk($sformatf("v%0d_taken", idx), {31'd0, taken}, {31'd0, v.exp_taken});
    chk($sformatf("v%0d_req_ready_eval", idx), {31'd0, req_ready}, 32'd0);
    tick();
    chk($sformatf("v%0d_resolve_pulse", idx), {31'd0, resolve_valid}, 32'd0);
    chk($sformatf("v%0d_redir_valid", idx), {31'd0, redir_valid}, {31'd0, v.exp_redir});
    if (v.exp_redir) begin
      chk($sformatf("v%0d_redir_pc", idx), redir_pc, v.exp_pc);
      chk($sformatf("v%0d_flush_pre", idx), {31'd0, flush}, 32'd0);
      redir_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_flush", idx), {31'd0, flush}, 32'd1);
      tick();
      redir_ready = 1'b0;
      chk($sformatf("v%0d_flush_post", idx), {31'd0, flush}, 32'd0);
      chk($sformatf("v%0d_redir_drop", idx), {31'd0, redir_valid}, 32'd0);
    end else begin
      chk($sformatf("v%0d_flush_none", idx), {31'd0, flush}, 32'd0);
    end
    chk($sformatf("v%0d_req_ready_back", idx), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] sat_exp [3];
    vec_t        uncond;

    //            op       a             b             pc4           tgt           pred  tkn   redir pc
    vecs[0]  = '{4'b0001, 32'd5,        32'd7,        32'h0000_0104, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{4'b0110, 32'hFFFF_FFFF, 32'd123,     32'h0000_0304, 32'h0000_0400, 1'b0, 1'b1, 1'b1, 32'h0000_0400};
    vecs[2]  = '{4'b1101, 32'd0,        32'd9,        32'h0000_0104, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'h0000_0104};
    vecs[3]  = '{4'b0010, 32'h8000_0000, 32'd1,       32'h0000_0604, 32'h0000_0700, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{4'b1000, 32'd1,        32'd2,        32'h0000_0804, 32'h0000_0900, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{4'b0000, 32'd0,        32'd0,        32'h0000_0A04, 32'h0000_0B00, 1'b1, 1'b0, 1'b1, 32'h0000_0A04};
    vecs[6]  = '{4'b0010, 32'd3,        32'd9,        32'h0000_0C04, 32'h0000_0D00, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{4'b1010, 32'd3,        32'd9,        32'h0000_0E04, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{4'b0011, 32'd9,        32'd9,        32'h0000_1004, 32'h0000_1100, 1'b0, 1'b1, 1'b1, 32'h0000_1100};
    vecs[9]  = '{4'b1011, 32'd10,       32'd9,        32'h0000_1204, 32'h0000_1300, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{4'b1001, 32'd7,        32'd7,        32'h0000_1404, 32'h0000_1500, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{4'b0101, 32'd0,        32'd55,       32'h0000_1604, 32'h0000_1700, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{4'b0100, 32'd0,        32'd0,        32'h0000_1804, 32'h0000_1900, 1'b1, 1'b0, 1'b1, 32'h0000_1804};
    uncond   = '{4'b1000, 32'd0,        32'd0,        32'h0000_2204, 32'h0000_2300, 1'b1, 1'b1, 1'b0, 32'h0};
    sat_exp[0] = 16'hFFFE;
    sat_exp[1] = 16'hFFFF;
    sat_exp[2] = 16'hFFFF;

    reset_n     = 1'b0;
    req_valid   = 1'b0;
    redir_ready = 1'b0;
    opCond      = 4'b0000;
    srcA        = 32'd0;
    srcB        = 32'd0;
    pcPlus4     = 32'd0;
    target      = 32'd0;
    predTaken   = 1'b0;
    exp_cnt     = 16'h0000;

    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_taken_count", {16'd0, taken_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
      if (vecs[i].exp_taken) exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("v%0d_taken_count", i), {16'd0, taken_count}, {16'd0, exp_cnt});
    end

    // Mispredicted BLTZ with redirect held off for three cycles; stray redir_ready/req_valid ignored.
    redir_ready = 1'b1;
    #1;
    chk("idle_redir_ready_no_flush", {31'd0, flush}, 32'd0);
    opCond    = 4'b0110;
    srcA      = 32'hFFFF_FFFF;
    srcB      = 32'd123;
    pcPlus4   = 32'h0000_1F04;
    target    = 32'h0000_2000;
    predTaken = 1'b0;
    req_valid = 1'b1;
    tick();
    chk("hold_eval_no_flush", {31'd0, flush}, 32'd0);
    chk("hold_taken", {31'd0, taken}, 32'd1);
    redir_ready = 1'b0;
    target      = 32'h0000_3000;
    srcA        = 32'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d_redir_valid", i), {31'd0, redir_valid}, 32'd1);
      chk($sformatf("hold%0d_redir_pc", i), redir_pc, 32'h0000_2000);
      chk($sformatf("hold%0d_flush", i), {31'd0, flush}, 32'd0);
      chk($sformatf("hold%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid   = 1'b0;
    redir_ready = 1'b1;
    #1;
    chk("hold_flush", {31'd0, flush}, 32'd1);
    chk("hold_redir_pc_ack", redir_pc, 32'h0000_2000);
    tick();
    redir_ready = 1'b0;
    exp_cnt     = exp_cnt + 16'd1;
    chk("hold_flush_post", {31'd0, flush}, 32'd0);
    chk("hold_redir_drop", {31'd0, redir_valid}, 32'd0);
    chk("hold_req_ready", {31'd0, req_ready}, 32'd1);
    chk("hold_taken_count", {16'd0, taken_count}, {16'd0, exp_cnt});

    // Saturation: preload the counter near the top, then run real taken branches.
    force dut.r_taken_count = 16'hFFFD;
    #1;
    release dut.r_taken_count;
    #1;
    chk("sat_preload", {16'd0, taken_count}, 32'h0000_FFFD);
    for (int i = 0; i < 3; i++) begin
      run_vec(uncond, 20 + i);
      chk($sformatf("sat%0d_count", i), {16'd0, taken_count}, {16'd0, sat_exp[i]});
    end

    // Reset dropped asynchronously while a redirect is pending.
    opCond    = 4'b0000;
    predTaken = 1'b1;
    pcPlus4   = 32'h0000_4004;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_redir_valid_pre", {31'd0, redir_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("mid_flush", {31'd0, flush}, 32'd0);
    chk("mid_resolve_valid", {31'd0, resolve_valid}, 32'd0);
    chk("mid_taken_count", {16'd0, taken_count}, 32'd0);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_redir_pc", redir_pc, 32'd0);
    reset_n   = 1'b1;
    opCond    = 4'b1000;
    predTaken = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("post_rst_resolve", {31'd0, resolve_valid}, 32'd1);
    chk("post_rst_taken", {31'd0, taken}, 32'd1);
    tick();
    chk("post_rst_count", {16'd0, taken_count}, 32'd1);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
